// File: rtl/alu_seq.sv
// alu_seq: registered, valid/ready handshaked ALU with a multi-cycle shift-add multiplier.
//   CLK, RST_N            rising-edge clock, asynchronous active-low reset
//   IN_VALID/IN_READY     operation handshake (OPCODE, OPERAND_A, OPERAND_B)
//   OUT_VALID/OUT_READY   result handshake (ALU_OUT, MUL_HI, CARRY_FLAG, ZERO_FLAG)
//   BUSY                  multiplier iterating
module alu_seq #(
    parameter int DATA_W = 8,
    parameter int SH_W   = $clog2(DATA_W)
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [4:0]        OPCODE,
    input  logic [DATA_W-1:0] OPERAND_A,
    input  logic [DATA_W-1:0] OPERAND_B,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [DATA_W-1:0] ALU_OUT,
    output logic [DATA_W-1:0] MUL_HI,
    output logic              CARRY_FLAG,
    output logic              ZERO_FLAG,
    output logic              BUSY
);
    localparam logic [4:0] OP_SRL = 5'd0, OP_SRA = 5'd1, OP_SL = 5'd2, OP_ROL = 5'd3,
                           OP_ROR = 5'd4, OP_AND = 5'd5, OP_OR = 5'd6, OP_NOT = 5'd7,
                           OP_XOR = 5'd8, OP_ADD = 5'd9, OP_SUB = 5'd10, OP_LT = 5'd11,
                           OP_GT = 5'd12, OP_EQ = 5'd13, OP_GTE = 5'd14, OP_LTE = 5'd15,
                           OP_NE = 5'd16, OP_MUL = 5'd17;
    localparam logic [DATA_W-2:0] PAD = '0;
    typedef enum logic {IDLE, MUL} state_t;
    state_t state_q, state_d;
    logic [2*DATA_W-1:0] mcand_q, mcand_d, acc_q, acc_d, acc_sum, rol_w, ror_w;
    logic [DATA_W-1:0] mplier_q, mplier_d, alu_out_q, alu_out_d, mul_hi_q, mul_hi_d, res;
    logic [SH_W-1:0] cnt_q, cnt_d, amt;
    logic out_valid_q, out_valid_d, carry_q, carry_d, zero_q, zero_d;
    logic accept, last, big, res_c;
    logic [DATA_W:0] sum;
    assign IN_READY   = (state_q == IDLE) & (~out_valid_q | OUT_READY);
    assign accept     = IN_VALID & IN_READY;
    assign BUSY       = state_q == MUL;
    assign OUT_VALID  = out_valid_q;
    assign ALU_OUT    = alu_out_q;
    assign MUL_HI     = mul_hi_q;
    assign CARRY_FLAG = carry_q;
    assign ZERO_FLAG  = zero_q;
    // any bit at or above SH_W means the shift amount is >= DATA_W
    assign big     = |(OPERAND_B >> SH_W);
    assign amt     = OPERAND_B[SH_W-1:0];
    assign rol_w   = {OPERAND_A, OPERAND_A} << amt;
    assign ror_w   = {OPERAND_A, OPERAND_A} >> amt;
    assign sum     = {1'b0, OPERAND_A} + {1'b0, OPERAND_B};
    assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign last    = cnt_q == SH_W'(DATA_W - 1);
    always_comb begin
        res   = '0;
        res_c = 1'b0;
        case (OPCODE)
            OP_SRL: res = big ? '0 : OPERAND_A >> amt;
            OP_SRA: res = big ? {DATA_W{OPERAND_A[DATA_W-1]}} : DATA_W'($signed(OPERAND_A) >>> amt);
            OP_SL:  res = big ? '0 : OPERAND_A << amt;
            OP_ROL: res = rol_w[2*DATA_W-1:DATA_W];
            OP_ROR: res = ror_w[DATA_W-1:0];
            OP_AND: res = OPERAND_A & OPERAND_B;
            OP_OR:  res = OPERAND_A | OPERAND_B;
            OP_NOT: res = ~OPERAND_A;
            OP_XOR: res = OPERAND_A ^ OPERAND_B;
            OP_ADD: {res_c, res} = sum;
            OP_SUB: begin
                res   = OPERAND_A - OPERAND_B;
                res_c = OPERAND_A < OPERAND_B;
            end
            OP_LT:  res = {PAD, OPERAND_A <  OPERAND_B};
            OP_GT:  res = {PAD, OPERAND_A >  OPERAND_B};
            OP_EQ:  res = {PAD, OPERAND_A == OPERAND_B};
            OP_GTE: res = {PAD, OPERAND_A >= OPERAND_B};
            OP_LTE: res = {PAD, OPERAND_A <= OPERAND_B};
            OP_NE:  res = {PAD, OPERAND_A != OPERAND_B};
            default: res = '0;
        endcase
    end
    always_comb begin
        state_d     = state_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        alu_out_d   = alu_out_q;
        mul_hi_d    = mul_hi_q;
        carry_d     = carry_q;
        zero_d      = zero_q;
        out_valid_d = out_valid_q & ~OUT_READY;
        if (state_q == IDLE) begin
            if (accept && OPCODE == OP_MUL) begin
                state_d  = MUL;
                mcand_d  = {{DATA_W{1'b0}}, OPERAND_A};
                mplier_d = OPERAND_B;
                acc_d    = '0;
                cnt_d    = '0;
            end else if (accept) begin
                out_valid_d = 1'b1;
                alu_out_d   = res;
                mul_hi_d    = '0;
                carry_d     = res_c;
                zero_d      = res == '0;
            end
        end else begin
            // one radix-2 step: add the shifted multiplicand when the low multiplier bit is set
            acc_d    = acc_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (last) begin
                state_d               = IDLE;
                out_valid_d           = 1'b1;
                {mul_hi_d, alu_out_d} = acc_sum;
                carry_d               = 1'b0;
                zero_d                = acc_sum == '0;
            end
        end
    end
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            alu_out_q   <= '0;
            mul_hi_q    <= '0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            alu_out_q   <= alu_out_d;
            mul_hi_q    <= mul_hi_d;
            carry_q     <= carry_d;
            zero_q      <= zero_d;
        end
    end
endmodule
